// File: rtl/aesl_deadlock_block_detector.sv
// Deadlock detector for a dataflow kernel. It watches the AXI-Stream and
// sub-instance blocking signals. It declares a deadlock once the same
// blocking pattern has persisted for BLOCK_THRESHOLD consecutive cycles
// while at least one sub-instance is busy.
module aesl_deadlock_block_detector #(
  parameter int unsigned NUM_AXIS        = 2,
  parameter int unsigned NUM_INST        = 1,
  parameter int unsigned BLOCK_THRESHOLD = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_INST-1:0]          inst_idle_sigs,
  input  logic [NUM_INST-1:0]          inst_block_sigs,
  output logic                         block,
  output logic [NUM_INST+NUM_AXIS-1:0] block_sig,
  output logic [7:0]                   block_events
);

  localparam int unsigned SW = NUM_INST + NUM_AXIS;
  localparam int unsigned CW = $clog2(BLOCK_THRESHOLD + 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntLast = CW'(BLOCK_THRESHOLD - 1);

  typedef enum logic [1:0] {StIdle, StWatch, StBlocked} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sig_q, sig_d;
  logic [SW-1:0]   block_sig_q, block_sig_d;
  logic [7:0]      events_q, events_d;
  logic            block_q;
  logic            stall;
  logic [SW-1:0]   sig;

  // Stall only counts while some sub-instance is still busy.
  always_comb begin
    sig   = {inst_block_sigs, axis_block_sigs};
    stall = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
  end

  // Next-state logic: count a stable stall pattern and declare on the last cycle of the window.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sig_d       = sig_q;
    block_sig_d = block_sig_q;
    events_d    = events_q;
    case (state_q)
      StIdle: begin
        if (stall) begin
          state_d = StWatch;
          cnt_d   = CntOne;
          sig_d   = sig;
        end else begin
          cnt_d = '0;
        end
      end
      StWatch: begin
        if (!stall) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sig != sig_q) begin
          // Blocking pattern moved: restart the window on the new pattern.
          sig_d = sig;
          cnt_d = CntOne;
        end else if (cnt_q < CntLast) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          state_d     = StBlocked;
          block_sig_d = sig;
          if (events_q != 8'hFF) begin
            events_d = events_q + 8'd1;
          end
        end
      end
      StBlocked: begin
        if (!stall) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers. The block flag is registered from the next state so the output has no input path.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sig_q       <= '0;
      block_sig_q <= '0;
      events_q    <= '0;
      block_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_q       <= sig_d;
      block_sig_q <= block_sig_d;
      events_q    <= events_d;
      block_q     <= (state_d == StBlocked);
    end
  end

  assign block        = block_q;
  assign block_sig    = block_sig_q;
  assign block_events = events_q;

endmodule

// File: tb/tb_aesl_deadlock_block_detector.sv
// Scoreboard bench for the deadlock detector with THRESHOLD=4. Each stimulus step
// pushes the hand-computed outputs expected after the next edge. A negedge
// monitor pops the entries and compares them.
module tb_aesl_deadlock_block_detector;

  localparam int unsigned TH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] axis_block_sigs = 2'b00;
  logic [0:0] inst_idle_sigs  = 1'b0;
  logic [0:0] inst_block_sigs = 1'b0;
  logic       block;
  logic [2:0] block_sig;
  logic [7:0] block_events;

  aesl_deadlock_block_detector #(
    .NUM_AXIS(2),
    .NUM_INST(1),
    .BLOCK_THRESHOLD(TH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .block(block),
    .block_sig(block_sig),
    .block_events(block_events)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic       blk;
    logic [2:0] sig;
    logic [7:0] ev;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic compare(input string nm, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got blk=%b sig=%b ev=%0d, expected blk=%b sig=%b ev=%0d", nm,
               got[11], got[10:8], got[7:0], exp[11], exp[10:8], exp[7:0]);
    end
  endtask

  // Monitor: compare every entry whose target cycle has arrived.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s: stale entry for cycle %0d, now %0d", e.name, e.cyc, cyc);
        end else begin
          compare(e.name, {block, block_sig, block_events}, {e.blk, e.sig, e.ev});
        end
      end
    end
  end

  task automatic push(input string nm, input int c, input logic eb, input logic [2:0] es,
                      input logic [7:0] ee);
    exp_t e;
    e.cyc  = c;
    e.blk  = eb;
    e.sig  = es;
    e.ev   = ee;
    e.name = nm;
    sb.push_back(e);
  endtask

  // One clock of stimulus plus the outputs expected after the following edge.
  task automatic step(input string nm, input logic [1:0] ax, input logic idl, input logic ib,
                      input logic eb, input logic [2:0] es, input logic [7:0] ee);
    @(negedge clock);
    #1;
    reset           = 1'b0;
    axis_block_sigs = ax;
    inst_idle_sigs  = idl;
    inst_block_sigs = ib;
    push(nm, cyc + 1, eb, es, ee);
  endtask

  // Assert reset between edges; outputs must clear at once, without waiting for a clock.
  task automatic pulse_reset(input string nm);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    compare({nm, "_async"}, {block, block_sig, block_events}, 12'h000);
    push(nm, cyc + 1, 1'b0, 3'b000, 8'd0);
  endtask

  int exp_prev, exp_now;

  initial begin
    #2;
    compare("reset_async", {block, block_sig, block_events}, 12'h000);
    push("reset_edge", 1, 1'b0, 3'b000, 8'd0);

    // Basic declaration after four edges of an unchanged pattern.
    step("a1", 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
    step("a2", 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
    step("a3", 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
    step("a4_declare", 2'b01, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1);
    step("a5_hold", 2'b01, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1);
    step("a6_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 8'd1);

    // Re-stall needs a full new window; the snapshot stays frozen while blocked.
    step("d1", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'd1);
    step("d2", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'd1);
    step("d3", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'd1);
    step("d4_declare", 2'b01, 1'b0, 1'b0, 1'b1, 3'b001, 8'd2);
    step("d5_sig_moves", 2'b10, 1'b0, 1'b0, 1'b1, 3'b001, 8'd2);
    step("d6_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);

    // A pattern change restarts the window.
    step("b1", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);
    step("b2", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);
    step("b3", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);
    step("b4_change", 2'b10, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);
    step("b5", 2'b10, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);
    step("b6", 2'b10, 1'b0, 1'b0, 1'b0, 3'b001, 8'd2);
    step("b7_declare", 2'b10, 1'b0, 1'b0, 1'b1, 3'b010, 8'd3);
    step("b8_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);

    // A single progress cycle resets the count.
    step("c1", 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c2", 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c3", 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c4_gap", 2'b00, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c5", 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c6", 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c7", 2'b01, 1'b0, 1'b0, 1'b0, 3'b010, 8'd3);
    step("c8_declare", 2'b01, 1'b0, 1'b0, 1'b1, 3'b001, 8'd4);
    step("c9_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 8'd4);

    // A sub-instance block alone is enough to stall.
    step("i1", 2'b00, 1'b0, 1'b1, 1'b0, 3'b001, 8'd4);
    step("i2", 2'b00, 1'b0, 1'b1, 1'b0, 3'b001, 8'd4);
    step("i3", 2'b00, 1'b0, 1'b1, 1'b0, 3'b001, 8'd4);
    step("i4_declare", 2'b00, 1'b0, 1'b1, 1'b1, 3'b100, 8'd5);
    step("i5_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b100, 8'd5);

    // All instances idle: never a deadlock.
    for (int i = 0; i < 100; i++) begin
      step("idle_masks", 2'b11, 1'b1, 1'b1, 1'b0, 3'b100, 8'd5);
    end

    // Reset mid-window, then a full window from cnt=1.
    step("r1", 2'b01, 1'b0, 1'b0, 1'b0, 3'b100, 8'd5);
    step("r2", 2'b01, 1'b0, 1'b0, 1'b0, 3'b100, 8'd5);
    pulse_reset("r_reset");
    step("r3", 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
    step("r4", 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
    step("r5", 2'b01, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0);
    step("r6_declare", 2'b01, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1);
    step("r7_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 8'd1);

    // Event counter saturates at 255.
    for (int n = 2; n <= 260; n++) begin
      exp_prev = (n - 1 > 255) ? 255 : n - 1;
      exp_now  = (n > 255) ? 255 : n;
      step("sat_w1", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'(exp_prev));
      step("sat_w2", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'(exp_prev));
      step("sat_w3", 2'b01, 1'b0, 1'b0, 1'b0, 3'b001, 8'(exp_prev));
      step("sat_declare", 2'b01, 1'b0, 1'b0, 1'b1, 3'b001, 8'(exp_now));
      step("sat_clear", 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 8'(exp_now));
    end

    repeat (3) @(negedge clock);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
